// File: rtl/note_sequencer_ctrl.sv
// Control FSM for the note datapath: turns debounced key edges into store and
// playback strobes, and tracks how many notes the 16-entry memory holds.
module note_sequencer_ctrl #(
  parameter int NOTE_TICKS = 12_500_000,
  parameter int TICK_W     = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       store_key_i,
  input  logic       play_key_i,
  input  logic       stop_key_i,
  input  logic       loop_en_i,
  output logic       ld_note_o,
  output logic       ld_play_o,
  output logic       next_note_en_o,
  output logic [3:0] note_counter_o,
  output logic       display_note_o,
  output logic [4:0] note_count_o,
  output logic       full_o
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    STORE_GAP,
    PLAY_LOAD,
    PLAY_HOLD
  } state_t;

  // Hold ends one tick early because PLAY_LOAD itself is the first cycle of a note.
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(NOTE_TICKS - 2);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        noteIdx_q, noteIdx_d;
  logic [4:0]        noteCount_q, noteCount_d;
  logic              storeKey_q, playKey_q, stopKey_q;
  logic              storeRise, playRise, stopRise;

  assign storeRise = store_key_i & ~storeKey_q;
  assign playRise  = play_key_i  & ~playKey_q;
  assign stopRise  = stop_key_i  & ~stopKey_q;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    noteIdx_d   = noteIdx_q;
    noteCount_d = noteCount_q;
    case (state_q)
      IDLE: begin
        if (!stopRise) begin
          if (playRise) begin
            if (noteCount_q != 5'd0) begin
              state_d   = PLAY_LOAD;
              noteIdx_d = 4'd0;
            end
          end else if (storeRise) begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        if (noteCount_q != 5'd16) noteCount_d = noteCount_q + 5'd1;
        state_d = STORE_GAP;
      end
      STORE_GAP: state_d = IDLE;
      PLAY_LOAD: begin
        if (stopRise) begin
          state_d   = IDLE;
          noteIdx_d = 4'd0;
        end else begin
          tick_d  = '0;
          state_d = PLAY_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (stopRise) begin
          state_d   = IDLE;
          noteIdx_d = 4'd0;
        end else if (tick_q == LAST_TICK) begin
          if (({1'b0, noteIdx_q} + 5'd1) < noteCount_q) begin
            noteIdx_d = noteIdx_q + 4'd1;
            state_d   = PLAY_LOAD;
          end else begin
            noteIdx_d = 4'd0;
            state_d   = loop_en_i ? PLAY_LOAD : IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output is a clean flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      tick_q         <= '0;
      noteIdx_q      <= 4'd0;
      noteCount_q    <= 5'd0;
      storeKey_q     <= 1'b0;
      playKey_q      <= 1'b0;
      stopKey_q      <= 1'b0;
      ld_note_o      <= 1'b0;
      ld_play_o      <= 1'b0;
      next_note_en_o <= 1'b0;
      display_note_o <= 1'b0;
      full_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      noteIdx_q      <= noteIdx_d;
      noteCount_q    <= noteCount_d;
      storeKey_q     <= store_key_i;
      playKey_q      <= play_key_i;
      stopKey_q      <= stop_key_i;
      ld_note_o      <= (state_d == STORE);
      ld_play_o      <= (state_d == PLAY_LOAD) || (state_d == PLAY_HOLD);
      next_note_en_o <= (state_d == PLAY_LOAD);
      display_note_o <= (state_d == PLAY_LOAD) || (state_d == PLAY_HOLD);
      full_o         <= (noteCount_d == 5'd16);
    end
  end

  assign note_counter_o = noteIdx_q;
  assign note_count_o   = noteCount_q;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Bench for note_sequencer_ctrl: directed scenarios with literal expectations,
// then randomized key activity compared every cycle against a timeline model.
module tb_note_sequencer_ctrl;
  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       storeKey = 1'b0, playKey = 1'b0, stopKey = 1'b0, loopEn = 1'b0;
  logic       ldNote, ldPlay, nextNoteEn, displayNote, full;
  logic [3:0] noteCounter;
  logic [4:0] noteCount;

  int total = 0;
  int bad = 0;

  note_sequencer_ctrl #(.NOTE_TICKS(NT), .TICK_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .store_key_i   (storeKey),
    .play_key_i    (playKey),
    .stop_key_i    (stopKey),
    .loop_en_i     (loopEn),
    .ld_note_o     (ldNote),
    .ld_play_o     (ldPlay),
    .next_note_en_o(nextNoteEn),
    .note_counter_o(noteCounter),
    .display_note_o(displayNote),
    .note_count_o  (noteCount),
    .full_o        (full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; the DUT sees them at the next edge.
  task automatic applyStimulus(input bit s, input bit p, input bit x, input bit l, input bit rstN);
    @(posedge clk);
    #1;
    storeKey = s;
    playKey  = p;
    stopKey  = x;
    loopEn   = l;
    reset    = rstN;
  endtask

  // Model: playback is a timeline starting at mSeg; each note spans NT cycles.
  bit modelValid = 0;
  int cyc = 0;
  int mCount = 0;
  int mStoreAt = -100;
  int mSeg = 0;
  bit mPlaying = 0;
  bit pS = 0, pP = 0, pX = 0;

  always @(negedge clk) begin
    bit sr, pr, xr;
    int expIdx;
    bit expNne;
    if (modelValid) begin
      expNne = mPlaying && (((cyc - mSeg) % NT) == 0);
      expIdx = mPlaying ? (cyc - mSeg) / NT : 0;
      checkOutput("model ld_note", 32'(ldNote), 32'(cyc == mStoreAt + 1));
      checkOutput("model ld_play", 32'(ldPlay), 32'(mPlaying));
      checkOutput("model display_note", 32'(displayNote), 32'(mPlaying));
      checkOutput("model next_note_en", 32'(nextNoteEn), 32'(expNne));
      checkOutput("model note_counter", 32'(noteCounter), 32'(expIdx));
      checkOutput("model note_count", 32'(noteCount), 32'(mCount));
      checkOutput("model full", 32'(full), 32'(mCount == 16));
    end
    if (!reset) begin
      modelValid = 1;
      mCount = 0;
      mStoreAt = -100;
      mPlaying = 0;
      mSeg = 0;
      pS = 0;
      pP = 0;
      pX = 0;
    end else begin
      sr = storeKey && !pS;
      pr = playKey && !pP;
      xr = stopKey && !pX;
      if (cyc == mStoreAt + 1 && mCount < 16) mCount++;
      if (mPlaying) begin
        if (xr) mPlaying = 0;
        else if (cyc - mSeg == mCount * NT - 1) begin
          if (loopEn) mSeg = cyc + 1;
          else mPlaying = 0;
        end
      end else if (cyc > mStoreAt + 2 && !xr) begin
        if (pr) begin
          if (mCount > 0) begin
            mPlaying = 1;
            mSeg = cyc + 1;
          end
        end else if (sr) mStoreAt = cyc;
      end
      pS = storeKey;
      pP = playKey;
      pX = stopKey;
    end
    cyc++;
  end

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic storeNote(input int expCount);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("store ld_note pulse", 32'(ldNote), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("store ld_note gap", 32'(ldNote), 0);
    checkOutput("store note_count", 32'(noteCount), 32'(expCount));
    checkOutput("store full", 32'(full), 32'(expCount == 16));
  endtask

  initial begin
    bit s, p, x, l;
    doReset();
    checkOutput("reset ld_play", 32'(ldPlay), 0);
    checkOutput("reset note_count", 32'(noteCount), 0);
    checkOutput("reset note_counter", 32'(noteCounter), 0);
    checkOutput("reset full", 32'(full), 0);

    for (int i = 1; i <= 3; i++) storeNote(i);

    // Plain playback of three notes.
    applyStimulus(0, 1, 0, 0, 1);
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("play next_note_en", 32'(nextNoteEn), 32'(k == 1 || k == 5 || k == 9));
      checkOutput("play ld_play", 32'(ldPlay), 32'(k <= 12));
      checkOutput("play note_counter", 32'(noteCounter), 32'(k <= 12 ? (k - 1) / 4 : 0));
    end

    // Looping playback, stopped after the wrap.
    applyStimulus(0, 1, 0, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 0, k == 14, 1, 1);
      checkOutput("loop next_note_en", 32'(nextNoteEn), 32'(k == 1 || k == 5 || k == 9 || k == 13));
      checkOutput("loop ld_play", 32'(ldPlay), 32'(k <= 14));
      checkOutput("loop note_counter", 32'(noteCounter), 32'(k <= 14 ? ((k - 1) % 12) / 4 : 0));
    end

    // Stop during the second note.
    applyStimulus(0, 1, 0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, k == 6, 1, 1);
      checkOutput("stop ld_play", 32'(ldPlay), 32'(k <= 6));
      if (k >= 7) checkOutput("stop note_counter", 32'(noteCounter), 0);
    end
    applyStimulus(0, 0, 0, 0, 1);

    // Play with an empty memory.
    doReset();
    applyStimulus(0, 1, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("empty ld_play", 32'(ldPlay), 0);
      checkOutput("empty next_note_en", 32'(nextNoteEn), 0);
    end

    // Fill past capacity.
    for (int i = 1; i <= 17; i++) storeNote(i > 16 ? 16 : i);

    // Reset in the middle of a note.
    doReset();
    storeNote(1);
    storeNote(2);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midplay ld_play before reset", 32'(ldPlay), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("midplay ld_play", 32'(ldPlay), 0);
    checkOutput("midplay display_note", 32'(displayNote), 0);
    checkOutput("midplay next_note_en", 32'(nextNoteEn), 0);
    checkOutput("midplay note_counter", 32'(noteCounter), 0);
    checkOutput("midplay note_count", 32'(noteCount), 0);
    applyStimulus(0, 1, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("midplay replay ld_play", 32'(ldPlay), 0);
    end

    // Random key activity, checked by the model process.
    s = 0; p = 0; x = 0; l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      if ($urandom_range(0, 5) == 0) p = ~p;
      if ($urandom_range(0, 11) == 0) x = ~x;
      if ($urandom_range(0, 19) == 0) l = ~l;
      applyStimulus(s, p, x, l, $urandom_range(0, 299) != 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer_ctrl.md
# note_sequencer_ctrl

Control FSM for the music-device note datapath. It turns debounced user keys (store, play, stop, loop) into the datapath control strobes `ld_note`, `ld_play`, `next_note_en` and `note_counter`. It tracks how many notes are in the 16-entry note memory. During playback it steps through the stored notes at a fixed per-note duration. It sits between the key/debounce logic and the datapath in the top level.

## Interface
- `NOTE_TICKS`, default 12_500_000: clock cycles each note plays, including its load cycle. Legal values are 2 to 2^TICK_W.
- `TICK_W`, default 26: width of the duration counter.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `store_key`  in  1  debounced level; a rising edge requests storing the current note/octave
- `play_key`  in  1  debounced level; a rising edge requests playback from index 0
- `stop_key`  in  1  debounced level; a rising edge aborts playback
- `loop_en`  in  1  level; when high, playback restarts at index 0 after the last note
- `ld_note`  out  1  one-cycle write strobe to the datapath
- `ld_play`  out  1  high for the whole of playback
- `next_note_en`  out  1  one-cycle strobe; the datapath loads `note_counter` as the memory address
- `note_counter`  out  4  playback index
- `display_note`  out  1  high while playing (drives the VGA highlight)
- `note_count`  out  5  number of valid stored notes, 0 to 16
- `full`  out  1  high when `note_count` is 16

## Operation
- Edge detection: each key has a registered copy. A rising edge is `key & ~key_d`. Only rising edges act; held keys do nothing further.
- Request priority within a cycle: stop > play > store.
- States:
  - IDLE: wait for a request.
    - Store edge → STORE.
    - Play edge with `note_count` ≠ 0 → PLAY_LOAD.
    - Play edge with `note_count` = 0 → ignored.
    - Stop edge → ignored.
  - STORE: `ld_note` = 1 for one cycle. `note_count` increments, saturating at 16. Next state is STORE_GAP.
  - STORE_GAP: `ld_note` = 0 for one cycle, which lets the datapath re-arm its write enable. Next state is IDLE.
  - PLAY_LOAD: `ld_play` = 1, `next_note_en` = 1, `display_note` = 1. The tick counter clears to 0. Next state is PLAY_HOLD.
  - PLAY_HOLD: `ld_play` = 1, `display_note` = 1, and the tick counter increments each cycle. When tick = NOTE_TICKS−2:
    - Index < `note_count`−1: index+1 → PLAY_LOAD.
    - Index = `note_count`−1 and `loop_en` = 1: index 0 → PLAY_LOAD.
    - Otherwise: IDLE, with index cleared to 0.
- Stop edge in PLAY_LOAD or PLAY_HOLD: go to IDLE next cycle and clear the index to 0.
- Store and play edges while playing are ignored.
- Stores are always allowed, including when full:
  - the datapath address wraps 15→0 and overwrites;
  - `note_count` stays at 16.
- `note_count` is cleared only by reset. The datapath memory address is also reset only by reset, so the two stay aligned. The first store after reset goes to address 0.
- All outputs are Moore outputs, decoded from registered state and counters.

## Timing
- Reset values:
  - state IDLE;
  - `ld_note`, `ld_play`, `next_note_en`, `display_note` = 0;
  - `note_counter` = 0, `note_count` = 0, `full` = 0;
  - tick counter = 0; key_d registers = 0.
- Reset asserted mid-store or mid-play: all of the above take effect at the next clock edge, and no further strobes are issued.
- Store latency:
  - edge seen in cycle n → `ld_note` high in cycle n+1;
  - `note_count` shows the new value in cycle n+2;
  - back in IDLE in cycle n+3.
- Back-to-back stores need a new rising edge, so the minimum spacing is 3 cycles.
- Play latency:
  - edge in cycle n → PLAY_LOAD in cycle n+1, with `note_counter` = 0 and `next_note_en` = 1;
  - each note spans exactly NOTE_TICKS cycles, measured from one `next_note_en` to the next;
  - after the last note, `ld_play` falls exactly N·NOTE_TICKS cycles after the first `next_note_en`.
- `note_counter` changes only in the cycle that enters PLAY_LOAD, or on return to IDLE.
- `loop_en` is sampled only at the end of the last note.

## Test plan
- Reset, then 3 store edges:
  - `ld_note` pulses are exactly 1 cycle each, with at least 1 low cycle between them;
  - `note_count` reads 1, 2, 3 in turn;
  - `full` = 0.
- With NOTE_TICKS=4 and 3 notes stored, a play edge produces:
  - `next_note_en` at cycles n+1, n+5, n+9;
  - `note_counter` = 0, 1, 2 at those cycles;
  - `ld_play` high from n+1 to n+12 and low at n+13;
  - `note_counter` = 0 afterwards.
- Same setup with `loop_en` = 1: after index 2, the next `next_note_en` (cycle n+13) has `note_counter` = 0. A stop edge at n+6 gives `ld_play` = 0 at n+7.
- Play edge with `note_count` = 0 → the FSM stays in IDLE and every strobe stays low.
- 17 store edges → `note_count` = 16 and `full` = 1 after the 16th, and both remain unchanged after the 17th. The 17th `ld_note` still pulses.
- Reset driven low during PLAY_HOLD (NOTE_TICKS=4, 2 notes stored) → the next cycle shows every output at its reset value and `note_count` = 0. A play edge then does nothing until new notes are stored.
